// File: rtl/fetch_stage.sv
// fetch_stage: PC + BTB branch prediction, decode-resolved redirect, HLT freeze and IF/ID register
module fetch_stage #(
    parameter int          BTB_IDX_W = 3,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        id_is_branch,
    input  logic        id_branch_taken,
    input  logic [15:0] id_branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_inst,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_pc_next,
    output logic        if_id_valid,
    output logic        fetch_halted
);
    localparam int N     = 1 << BTB_IDX_W;
    localparam int TAG_W = 15 - BTB_IDX_W;

    logic [15:0] pc_q, pc_d, inst_q, inst_d, ifpc_q, ifpc_d, ifpcn_q, ifpcn_d, ptgt_q, ptgt_d;
    logic        valid_q, valid_d, halt_q, halt_d, ptkn_q, ptkn_d;
    logic [N-1:0]            btb_vld_q, btb_vld_d;
    logic [N-1:0][1:0]       btb_ctr_q, btb_ctr_d;
    logic [N-1:0][TAG_W-1:0] btb_tag_q, btb_tag_d;
    logic [N-1:0][15:0]      btb_tgt_q, btb_tgt_d;

    logic [BTB_IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0]     f_tag, u_tag;
    logic [15:0]          pc_plus2, next_fetch, correct_pc;
    logic                 f_hit, pred_taken, u_hit, mispredict, is_hlt;

    assign f_idx      = pc_q[BTB_IDX_W:1];
    assign f_tag      = pc_q[15:BTB_IDX_W+1];
    assign u_idx      = ifpc_q[BTB_IDX_W:1];
    assign u_tag      = ifpc_q[15:BTB_IDX_W+1];
    assign f_hit      = btb_vld_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    assign u_hit      = btb_vld_q[u_idx] && (btb_tag_q[u_idx] == u_tag);
    assign pred_taken = f_hit && btb_ctr_q[f_idx][1];
    assign pc_plus2   = pc_q + 16'd2;
    assign next_fetch = pred_taken ? btb_tgt_q[f_idx] : pc_plus2;
    assign is_hlt     = imem_data[15:12] == 4'hF;
    assign correct_pc = (id_is_branch && id_branch_taken) ? id_branch_target : ifpcn_q;
    // A non-branch predicted taken is a BTB alias and must be undone like a mispredict.
    assign mispredict = valid_q && (id_is_branch
                        ? ((ptkn_q != id_branch_taken) || (id_branch_taken && (ptgt_q != id_branch_target)))
                        : ptkn_q);

    always_comb begin
        pc_d      = pc_q;
        inst_d    = inst_q;
        ifpc_d    = ifpc_q;
        ifpcn_d   = ifpcn_q;
        valid_d   = valid_q;
        halt_d    = halt_q;
        ptkn_d    = ptkn_q;
        ptgt_d    = ptgt_q;
        btb_vld_d = btb_vld_q;
        btb_ctr_d = btb_ctr_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        if (!stall) begin
            if (mispredict || halt_q) begin
                pc_d    = mispredict ? correct_pc : pc_q;
                halt_d  = mispredict ? 1'b0 : halt_q;
                inst_d  = '0;
                valid_d = 1'b0;
                ptkn_d  = 1'b0;
                ptgt_d  = '0;
            end else begin
                pc_d    = is_hlt ? pc_q : next_fetch;
                halt_d  = is_hlt;
                inst_d  = imem_data;
                ifpc_d  = pc_q;
                ifpcn_d = pc_plus2;
                valid_d = 1'b1;
                ptkn_d  = pred_taken;
                ptgt_d  = btb_tgt_q[f_idx];
            end
            if (valid_q && id_is_branch && u_hit) begin
                btb_ctr_d[u_idx] = id_branch_taken
                                   ? ((btb_ctr_q[u_idx] == 2'b11) ? 2'b11 : btb_ctr_q[u_idx] + 2'd1)
                                   : ((btb_ctr_q[u_idx] == 2'b00) ? 2'b00 : btb_ctr_q[u_idx] - 2'd1);
                btb_tgt_d[u_idx] = id_branch_taken ? id_branch_target : btb_tgt_q[u_idx];
            end else if (valid_q && id_is_branch && id_branch_taken) begin
                btb_vld_d[u_idx] = 1'b1;
                btb_tag_d[u_idx] = u_tag;
                btb_tgt_d[u_idx] = id_branch_target;
                btb_ctr_d[u_idx] = 2'b10;
            end else if (valid_q && !id_is_branch && u_hit && ptkn_q) begin
                btb_vld_d[u_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            ifpc_q    <= '0;
            ifpcn_q   <= '0;
            valid_q   <= 1'b0;
            halt_q    <= 1'b0;
            ptkn_q    <= 1'b0;
            ptgt_q    <= '0;
            btb_vld_q <= '0;
            btb_ctr_q <= '0;
            btb_tag_q <= '0;
            btb_tgt_q <= '0;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            ifpc_q    <= ifpc_d;
            ifpcn_q   <= ifpcn_d;
            valid_q   <= valid_d;
            halt_q    <= halt_d;
            ptkn_q    <= ptkn_d;
            ptgt_q    <= ptgt_d;
            btb_vld_q <= btb_vld_d;
            btb_ctr_q <= btb_ctr_d;
            btb_tag_q <= btb_tag_d;
            btb_tgt_q <= btb_tgt_d;
        end
    end

    assign imem_addr     = pc_q;
    assign if_id_inst    = inst_q;
    assign if_id_pc      = ifpc_q;
    assign if_id_pc_next = ifpcn_q;
    assign if_id_valid   = valid_q;
    assign fetch_halted  = halt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for sequential fetch, stall, BTB training/aliasing, HLT and reset
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        id_is_branch, id_branch_taken, force_br;
    logic [15:0] id_branch_target;
    logic [15:0] imem_addr, imem_data, if_id_inst, if_id_pc, if_id_pc_next;
    logic        if_id_valid, fetch_halted;
    logic [15:0] mem [0:127];
    int          passed = 0;
    int          total = 0;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [15:0] addr;
        logic [15:0] ifpc;
        logic        valid;
    } vec_t;
    vec_t tbl [8];

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_branch_target(id_branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_pc_next(if_id_pc_next),
        .if_id_valid(if_id_valid), .fetch_halted(fetch_halted)
    );

    always #5 clk = ~clk;

    // Opcode C is a branch; force_br makes decode treat whatever sits in IF/ID as a branch.
    assign imem_data    = mem[imem_addr[7:1]];
    assign id_is_branch = force_br | (if_id_valid & (if_id_inst[15:12] == 4'hC));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic [15:0] ea, input logic [15:0] ep, input logic ev, input logic eh);
        @(posedge clk);
        #1;
        chk("imem_addr", imem_addr, ea);
        chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, ev});
        chk("fetch_halted", {15'd0, fetch_halted}, {15'd0, eh});
        if (ev) begin
            chk("if_id_pc", if_id_pc, ep);
            chk("if_id_pc_next", if_id_pc_next, ep + 16'd2);
        end else begin
            chk("bubble_inst", if_id_inst, 16'h0000);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h1000;
        mem[8'h10 >> 1] = 16'hC000;
        mem[8'h44 >> 1] = 16'hC000;
        mem[8'h20 >> 1] = 16'hF000;
        force_br = 1'b0;
        id_branch_taken = 1'b1;
        id_branch_target = 16'h0040;
        tbl[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 16'h0004, 16'h0002, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 16'h0006, 16'h0004, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 16'h0006, 16'h0004, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 16'h0006, 16'h0004, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 16'h0006, 16'h0004, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 16'h0008, 16'h0006, 1'b1};
        for (int i = 0; i < 8; i++) begin
            rst_n = tbl[i].rst_n;
            stall = tbl[i].stall;
            step(tbl[i].addr, tbl[i].ifpc, tbl[i].valid, 1'b0);
            if (!tbl[i].rst_n) begin
                chk("reset_if_id_pc", if_id_pc, 16'h0000);
                chk("reset_if_id_pc_next", if_id_pc_next, 16'h0000);
            end
        end
        // cold taken branch at 0x10 -> 0x40: one bubble, stall holds the redirect off
        step(16'h000A, 16'h0008, 1, 0);
        step(16'h000C, 16'h000A, 1, 0);
        step(16'h000E, 16'h000C, 1, 0);
        step(16'h0010, 16'h000E, 1, 0);
        step(16'h0012, 16'h0010, 1, 0);
        chk("branch_inst", if_id_inst, 16'hC000);
        stall = 1'b1;
        step(16'h0012, 16'h0010, 1, 0);
        stall = 1'b0;
        step(16'h0040, 16'h0000, 0, 0);
        step(16'h0042, 16'h0040, 1, 0);
        id_branch_target = 16'h0010;
        step(16'h0044, 16'h0042, 1, 0);
        step(16'h0046, 16'h0044, 1, 0);
        step(16'h0010, 16'h0000, 0, 0);
        id_branch_target = 16'h0040;
        // trained branch: predicted taken, no bubble
        step(16'h0040, 16'h0010, 1, 0);
        step(16'h0042, 16'h0040, 1, 0);
        id_branch_target = 16'h0010;
        step(16'h0044, 16'h0042, 1, 0);
        step(16'h0010, 16'h0044, 1, 0);
        step(16'h0040, 16'h0010, 1, 0);
        id_branch_taken = 1'b0;
        // ctr 3 -> 2 on not-taken, then loop back for a second not-taken
        step(16'h0012, 16'h0000, 0, 0);
        step(16'h0014, 16'h0012, 1, 0);
        force_br = 1'b1; id_branch_taken = 1'b1; id_branch_target = 16'h0010;
        step(16'h0010, 16'h0000, 0, 0);
        force_br = 1'b0; id_branch_taken = 1'b0;
        step(16'h0040, 16'h0010, 1, 0);
        step(16'h0012, 16'h0000, 0, 0);
        // 0x12 entry now aliases a non-branch: predicted taken, squashed back to 0x14
        step(16'h0010, 16'h0012, 1, 0);
        step(16'h0014, 16'h0000, 0, 0);
        step(16'h0016, 16'h0014, 1, 0);
        force_br = 1'b1; id_branch_taken = 1'b1; id_branch_target = 16'h0010;
        step(16'h0010, 16'h0000, 0, 0);
        force_br = 1'b0; id_branch_taken = 1'b0;
        step(16'h0012, 16'h0010, 1, 0);
        step(16'h0014, 16'h0012, 1, 0);
        step(16'h0010, 16'h0014, 1, 0);
        step(16'h0016, 16'h0000, 0, 0);
        for (int k = 0; k < 5; k++) step(16'h0018 + 16'(2 * k), 16'h0016 + 16'(2 * k), 1, 0);
        // HLT at 0x20 freezes fetch
        step(16'h0020, 16'h0020, 1, 1);
        chk("hlt_inst", if_id_inst, 16'hF000);
        step(16'h0020, 16'h0000, 0, 1);
        step(16'h0020, 16'h0000, 0, 1);
        rst_n = 1'b0;
        step(16'h0000, 16'h0000, 0, 0);
        chk("rerst_if_id_pc", if_id_pc, 16'h0000);
        chk("rerst_if_id_pc_next", if_id_pc_next, 16'h0000);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) step(16'(2 * k), 16'(2 * k - 2), 1, 0);
        step(16'h0020, 16'h0020, 1, 1);
        // mispredict while HLT sits in IF/ID clears the halt
        force_br = 1'b1; id_branch_taken = 1'b1; id_branch_target = 16'h0040;
        step(16'h0040, 16'h0000, 0, 0);
        force_br = 1'b0;
        step(16'h0042, 16'h0040, 1, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
